mulres_fifo: RTL

Downstream of the 24x24 multiply/popcount engine. Captures every completed result (W = product[31:0], L = ones count, overflow flag) into a small FIFO so software can collect results at its own pace instead of racing the engine's single result register. Sits on the same bus (saddress/srd/swr/sdata_in/sdata_out) in the 0x03B0–0x03C8 window and raises a not-empty flag on a GPIO bit.

---
 rtl/gpioemu_pkg.sv | 25 ++
 rtl/strobe_sync.sv | 26 ++
 rtl/mulres_fifo.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/gpioemu_pkg.sv
// Shared constants and types for the multiply-result FIFO and its bus window.
package gpioemu_pkg;

  localparam logic [15:0] ADDR_FIFO_W   = 16'h03B0;
  localparam logic [15:0] ADDR_FIFO_L   = 16'h03B8;
  localparam logic [15:0] ADDR_FIFO_CTL = 16'h03C0;

  localparam int unsigned CTL_POP   = 0;
  localparam int unsigned CTL_CLR   = 1;
  localparam int unsigned CTL_FLUSH = 2;

  localparam int unsigned W_W = 32;
  localparam int unsigned W_L = 24;

  typedef struct packed {
    logic           ovf;
    logic [W_L-1:0] l;
    logic [W_W-1:0] w;
  } fifo_entry_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/strobe_sync.sv
// Two-flop synchronizer for an asynchronous bus strobe, plus a one-clk rising-edge pulse.
module strobe_sync (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic pulse
);

  // sync_q[0]/[1] are the synchronizer; sync_q[2] is the edge-detect delay stage.
  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], strobe};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/mulres_fifo.sv
// Result FIFO behind the multiply/popcount engine, read and controlled over the slow bus.
module mulres_fifo
  import gpioemu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           res_valid,
  input  logic [W_W-1:0] res_w,
  input  logic [W_L-1:0] res_l,
  input  logic           res_ovf,
  input  logic [15:0]    saddress,
  input  logic           srd,
  input  logic           swr,
  input  logic [31:0]    sdata_in,
  output logic [31:0]    sdata_out,
  output logic           fifo_nempty,
  output logic           fifo_full
);

  logic rd_evt, wr_evt;

  strobe_sync u_rd_sync (
    .clk    (clk),
    .reset  (reset),
    .strobe (srd),
    .pulse  (rd_evt)
  );

  strobe_sync u_wr_sync (
    .clk    (clk),
    .reset  (reset),
    .strobe (swr),
    .pulse  (wr_evt)
  );

  fifo_entry_t       mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic              drop_sticky_q, drop_sticky_d;
  logic [31:0]       sdata_out_q, sdata_out_d;

  logic        ctl_wr, pop_req, clr_req, flush_req;
  logic        do_push, do_pop, do_drop;
  fifo_entry_t push_entry, head;
  logic [7:0]  count_ext;
  logic [31:0] status_word;
  logic        unused_sdata;

  assign unused_sdata = ^sdata_in[31:3];

  assign fifo_full   = (count_q == (AW+1)'(DEPTH));
  assign fifo_nempty = (count_q != '0);

  assign ctl_wr    = wr_evt && (saddress == ADDR_FIFO_CTL);
  assign pop_req   = ctl_wr && sdata_in[CTL_POP];
  assign clr_req   = ctl_wr && sdata_in[CTL_CLR];
  assign flush_req = ctl_wr && sdata_in[CTL_FLUSH];

  // Flush discards any same-cycle push outright, so it neither stores nor counts as a drop.
  assign do_pop  = pop_req && fifo_nempty && !flush_req;
  assign do_push = res_valid && !flush_req && (!fifo_full || do_pop);
  assign do_drop = res_valid && !flush_req && fifo_full && !do_pop;

  assign push_entry = '{ovf: res_ovf, l: res_l, w: res_w};
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_req) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    drop_cnt_d    = drop_cnt_q;
    drop_sticky_d = drop_sticky_q;
    if (clr_req) begin
      drop_cnt_d    = '0;
      drop_sticky_d = 1'b0;
    end else if (do_drop) begin
      drop_cnt_d    = sat_inc8(drop_cnt_q);
      drop_sticky_d = 1'b1;
    end
  end

  always_comb begin
    count_ext   = 8'(count_q);
    status_word = {16'b0, drop_cnt_q, 2'b0, drop_sticky_q, fifo_full, fifo_nempty,
                   count_ext[2:0]};
    sdata_out_d = sdata_out_q;
    if (rd_evt) begin
      case (saddress)
        ADDR_FIFO_W:   sdata_out_d = fifo_nempty ? head.w : 32'b0;
        ADDR_FIFO_L:   sdata_out_d = fifo_nempty ? {7'b0, head.ovf, head.l} : 32'b0;
        ADDR_FIFO_CTL: sdata_out_d = status_word;
        default:       sdata_out_d = 32'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      drop_cnt_q    <= '0;
      drop_sticky_q <= 1'b0;
      sdata_out_q   <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      drop_cnt_q    <= drop_cnt_d;
      drop_sticky_q <= drop_sticky_d;
      sdata_out_q   <= sdata_out_d;
    end
  end

  // Storage needs no reset: an entry is only readable once count covers it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign sdata_out = sdata_out_q;

endmodule
